// File: rtl/bu_req_arbiter.sv
// rtl/bu_req_arbiter.sv - N-channel round-robin arbiter between biu_cell requesters and cache_bus_unit
//
// Purpose:
//   Arbitrates the L1 requesters (I, D, walker, prefetch) onto the single
//   shared cache_bus_unit. Only one transaction is in flight at a time.
//   When a transaction is granted, the arbiter latches the winner's attributes
//   and one request kind. It then routes the bus response strobes back to
//   the granted channel only.
//   FSM: IDLE -> GRANT -> BUSY -> DONE -> IDLE.
//
// Optional feature macro:
//   BU_TIMEOUT_EN  When defined, a BUSY watchdog runs. If TIMEOUT cycles pass
//                  with no response, it reports a bus error on the granted
//                  channel and ends the transaction.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   ch_wt_req/rd_req/rdline_req per-channel request levels [NCH]
//   ch_size/ch_pa/ch_wt_data    per-channel attributes, channel i at slice i
//   ch_line_data/addr_count     broadcast of the bus unit's data/count
//   ch_line_write, ch_cache_entry_write, ch_trans_rdy, ch_bus_error
//                               response strobes, granted channel only
//   bu_wt_req/rd_req/rdline_req request to cache_bus_unit (held through BUSY)
//   bu_size/bu_pa/bu_wt_data    latched request attributes
//   bu_line_data, bu_addr_count, bu_line_write, bu_cache_entry_write,
//   bu_trans_rdy, bu_bus_error  responses from cache_bus_unit
//   grant_id                    index of the current/last granted channel
//   busy                        high in GRANT and BUSY
module bu_req_arbiter #(
  parameter int NCH     = 2,
  parameter int PAW     = 64,
  parameter int DW      = 64,
  parameter int CNTW    = 11,
  parameter int TIMEOUT = 1024,
  localparam int GW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     ch_wt_req,
  input  logic [NCH-1:0]     ch_rd_req,
  input  logic [NCH-1:0]     ch_rdline_req,
  input  logic [4*NCH-1:0]   ch_size,
  input  logic [PAW*NCH-1:0] ch_pa,
  input  logic [DW*NCH-1:0]  ch_wt_data,
  output logic [DW-1:0]      ch_line_data,
  output logic [CNTW-1:0]    ch_addr_count,
  output logic [NCH-1:0]     ch_line_write,
  output logic [NCH-1:0]     ch_cache_entry_write,
  output logic [NCH-1:0]     ch_trans_rdy,
  output logic [NCH-1:0]     ch_bus_error,
  output logic               bu_wt_req,
  output logic               bu_rd_req,
  output logic               bu_rdline_req,
  output logic [3:0]         bu_size,
  output logic [PAW-1:0]     bu_pa,
  output logic [DW-1:0]      bu_wt_data,
  input  logic [DW-1:0]      bu_line_data,
  input  logic [CNTW-1:0]    bu_addr_count,
  input  logic               bu_line_write,
  input  logic               bu_cache_entry_write,
  input  logic               bu_trans_rdy,
  input  logic               bu_bus_error,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   ptr;
  logic [2:0]      kind;          // {wt, rdline, rd}, exactly one bit set once latched
  logic [NCH-1:0]  ch_req;
  logic            found;
  logic [GW-1:0]   win_idx;
  logic [GW-1:0]   cand;
  logic [3:0]      win_size;
  logic [PAW-1:0]  win_pa;
  logic [DW-1:0]   win_data;
  logic [2:0]      win_kind;
  logic [NCH-1:0]  grant_oh;
  logic            timeout_hit;
  logic            done_evt;

  assign ch_req = ch_wt_req | ch_rd_req | ch_rdline_req;

  // Round-robin search: the first requester after the last winner wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    cand     = '0;
    win_size = '0;
    win_pa   = '0;
    win_data = '0;
    win_kind = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = GW'((int'(ptr) + k) % NCH);
      if (!found && ch_req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (GW'(i) == win_idx) begin
        win_size = ch_size[4*i +: 4];
        win_pa   = ch_pa[PAW*i +: PAW];
        win_data = ch_wt_data[DW*i +: DW];
        // Only the highest-priority kind is issued: wt > rdline > rd.
        win_kind = {ch_wt_req[i],
                    !ch_wt_req[i] && ch_rdline_req[i],
                    !ch_wt_req[i] && !ch_rdline_req[i] && ch_rd_req[i]};
      end
    end
  end

`ifdef BU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == S_GRANT) begin
      to_cnt <= '0;
    end else if (state == S_BUSY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // The count starts at 0 in the first BUSY cycle, so TIMEOUT-1 is the
  // TIMEOUT-th cycle after GRANT. A real response in that cycle wins.
  assign timeout_hit = (state == S_BUSY) && (to_cnt == TW'(TIMEOUT - 1)) &&
                       !bu_trans_rdy && !bu_bus_error;
`else
  assign timeout_hit = 1'b0;
`endif

  assign done_evt = bu_trans_rdy | bu_bus_error | timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ptr           <= GW'(NCH - 1);
      grant_id      <= '0;
      kind          <= '0;
      bu_size       <= '0;
      bu_pa         <= '0;
      bu_wt_data    <= '0;
      bu_wt_req     <= 1'b0;
      bu_rd_req     <= 1'b0;
      bu_rdline_req <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (found) begin
            ptr        <= win_idx;
            grant_id   <= win_idx;
            kind       <= win_kind;
            bu_size    <= win_size;
            bu_pa      <= win_pa;
            bu_wt_data <= win_data;
          end
        end
        S_GRANT: begin
          bu_wt_req     <= kind[2];
          bu_rdline_req <= kind[1];
          bu_rd_req     <= kind[0];
        end
        S_BUSY: begin
          if (done_evt) begin
            bu_wt_req     <= 1'b0;
            bu_rdline_req <= 1'b0;
            bu_rd_req     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_BUSY;
      S_BUSY:  if (done_evt) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response strobes pass through only while BUSY, to the granted channel.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      grant_oh[i] = (GW'(i) == grant_id) && (state == S_BUSY);
    end
  end

  assign ch_line_write        = grant_oh & {NCH{bu_line_write}};
  assign ch_cache_entry_write = grant_oh & {NCH{bu_cache_entry_write}};
  assign ch_trans_rdy         = grant_oh & {NCH{bu_trans_rdy}};
  assign ch_bus_error         = grant_oh & {NCH{bu_bus_error | timeout_hit}};
  assign ch_line_data         = bu_line_data;
  assign ch_addr_count        = bu_addr_count;
  assign busy                 = (state == S_GRANT) || (state == S_BUSY);

endmodule

// File: tb/tb_bu_req_arbiter.sv
// tb/tb_bu_req_arbiter.sv - self-checking bench for bu_req_arbiter
module tb_bu_req_arbiter;
  localparam int NCH = 2, PAW = 64, DW = 64, CNTW = 11, TOUT = 16, GW = 1;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] wt_r, rd_r, rdl_r;
  logic [3:0]     sz [NCH];
  logic [PAW-1:0] pa [NCH];
  logic [DW-1:0]  wd [NCH];
  logic [4*NCH-1:0]   ch_size;
  logic [PAW*NCH-1:0] ch_pa;
  logic [DW*NCH-1:0]  ch_wt_data;
  logic [DW-1:0]   ch_line_data;
  logic [CNTW-1:0] ch_addr_count;
  logic [NCH-1:0]  ch_line_write, ch_cache_entry_write, ch_trans_rdy, ch_bus_error;
  logic bu_wt_req, bu_rd_req, bu_rdline_req;
  logic [3:0] bu_size;
  logic [PAW-1:0] bu_pa;
  logic [DW-1:0] bu_wt_data;
  logic [DW-1:0] bu_line_data;
  logic [CNTW-1:0] bu_addr_count;
  logic bu_line_write, bu_cache_entry_write, bu_trans_rdy, bu_bus_error;
  logic [GW-1:0] grant_id;
  logic busy;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int last_win;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_size[4*i +: 4]      = sz[i];
      ch_pa[PAW*i +: PAW]    = pa[i];
      ch_wt_data[DW*i +: DW] = wd[i];
    end
  end

  bu_req_arbiter #(.NCH(NCH), .PAW(PAW), .DW(DW), .CNTW(CNTW), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .ch_wt_req(wt_r), .ch_rd_req(rd_r), .ch_rdline_req(rdl_r),
    .ch_size(ch_size), .ch_pa(ch_pa), .ch_wt_data(ch_wt_data),
    .ch_line_data(ch_line_data), .ch_addr_count(ch_addr_count),
    .ch_line_write(ch_line_write), .ch_cache_entry_write(ch_cache_entry_write),
    .ch_trans_rdy(ch_trans_rdy), .ch_bus_error(ch_bus_error),
    .bu_wt_req(bu_wt_req), .bu_rd_req(bu_rd_req), .bu_rdline_req(bu_rdline_req),
    .bu_size(bu_size), .bu_pa(bu_pa), .bu_wt_data(bu_wt_data),
    .bu_line_data(bu_line_data), .bu_addr_count(bu_addr_count),
    .bu_line_write(bu_line_write), .bu_cache_entry_write(bu_cache_entry_write),
    .bu_trans_rdy(bu_trans_rdy), .bu_bus_error(bu_bus_error),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] oh(input bit b, input int w);
    logic [NCH-1:0] v;
    v = '0;
    if (b) v[w] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first requester after the previous winner, modulo NCH.
  function automatic int pick();
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (last_win + k) % NCH;
      if (wt_r[idx] || rd_r[idx] || rdl_r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NCH; i++) begin
      {wt_r[i], rd_r[i], rdl_r[i]} = 3'($urandom);
      sz[i] = 4'(1 << $urandom_range(0, 3));
      pa[i] = {$urandom, $urandom};
      wd[i] = {$urandom, $urandom};
    end
  endtask

  task automatic clear_reqs();
    wt_r = '0; rd_r = '0; rdl_r = '0;
  endtask

  // Called at a negedge with the DUT idle. mode: 0 trans_rdy, 1 bus_error, 2 both.
  task automatic run_txn(input int nlw, input bit lw_all, input int mode);
    int w;
    logic [2:0] ek;
    logic [PAW-1:0] epa;
    logic [DW-1:0] ewd;
    logic [3:0] esz;
    bit lw, ce, rdy, err;
    logic [DW-1:0] ld;
    w = pick();
    if (w < 0) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_bu_req", {bu_wt_req, bu_rdline_req, bu_rd_req}, 0);
      return;
    end
    ek  = wt_r[w] ? 3'b100 : (rdl_r[w] ? 3'b010 : 3'b001);
    epa = pa[w]; ewd = wd[w]; esz = sz[w];
    @(negedge clk);
    chk("grant_busy", busy, 1);
    chk("grant_id", grant_id, w);
    chk("grant_bu_req", {bu_wt_req, bu_rdline_req, bu_rd_req}, 0);
    rand_inputs();
    @(negedge clk);
    chk("busy_kind", {bu_wt_req, bu_rdline_req, bu_rd_req}, ek);
    chk("busy_pa", bu_pa, epa);
    chk("busy_size", bu_size, esz);
    chk("busy_wdata", bu_wt_data, ewd);
    for (int j = 0; j < nlw; j++) begin
      lw = lw_all ? 1'b1 : 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1));
      ld = {$urandom, $urandom};
      bu_line_write = lw; bu_cache_entry_write = ce; bu_line_data = ld;
      #1;
      chk("line_write", ch_line_write, oh(lw, w));
      chk("entry_write", ch_cache_entry_write, oh(ce, w));
      chk("line_data", ch_line_data, ld);
      chk("no_rdy_yet", ch_trans_rdy, 0);
      rand_inputs();
      @(negedge clk);
    end
    chk("held_pa", bu_pa, epa);
    chk("held_kind", {bu_wt_req, bu_rdline_req, bu_rd_req}, ek);
    bu_line_write = 1'b0; bu_cache_entry_write = 1'b0;
    rdy = (mode != 1); err = (mode != 0);
    bu_trans_rdy = rdy; bu_bus_error = err;
    #1;
    chk("resp_rdy", ch_trans_rdy, oh(rdy, w));
    chk("resp_err", ch_bus_error, oh(err, w));
    @(negedge clk);
    bu_trans_rdy = 1'b0; bu_bus_error = 1'b0;
    clear_reqs();
    #1;
    chk("done_busy", busy, 0);
    chk("done_bu_req", {bu_wt_req, bu_rdline_req, bu_rd_req}, 0);
    chk("done_strobes", {ch_trans_rdy, ch_bus_error, ch_line_write}, 0);
    @(negedge clk);
    chk("idle_after_busy", busy, 0);
    chk("idle_grant_id", grant_id, w);
    last_win = w;
  endtask

  initial begin
    int exp_w;
    rst = 1'b1;
    wt_r = '1; rd_r = '1; rdl_r = '1;
    for (int i = 0; i < NCH; i++) begin
      sz[i] = 4'b1000; pa[i] = '1; wd[i] = '1;
    end
    bu_line_data = '0; bu_addr_count = '0;
    bu_line_write = 1'b1; bu_cache_entry_write = 1'b1; bu_trans_rdy = 1'b1; bu_bus_error = 1'b1;

    // Reset with every channel requesting and the bus strobes all high.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_bu_req", {bu_wt_req, bu_rdline_req, bu_rd_req}, 0);
    chk("rst_attr", {bu_size, bu_pa, bu_wt_data}, 0);
    chk("rst_strobes", {ch_line_write, ch_cache_entry_write, ch_trans_rdy, ch_bus_error}, 0);
    clear_reqs();
    bu_line_write = 1'b0; bu_cache_entry_write = 1'b0; bu_trans_rdy = 1'b0; bu_bus_error = 1'b0;
    rst = 1'b0;
    last_win = NCH - 1;
    @(negedge clk);

    // ch1 line read alone, eight line_write beats.
    rdl_r[1] = 1'b1; pa[1] = 64'h8000_0040; sz[1] = 4'b1000;
    run_txn(8, 1'b1, 0);

    // ch0 wt+rd together: only the write is issued.
    wt_r[0] = 1'b1; rd_r[0] = 1'b1; wd[0] = 64'hDEAD_BEEF; sz[0] = 4'b0100; pa[0] = 64'h1000;
    run_txn(2, 1'b0, 0);

    // trans_rdy and bus_error together on ch1.
    rd_r[1] = 1'b1; pa[1] = 64'h2000;
    run_txn(1, 1'b0, 2);

    // Both channels hold their requests: grants must alternate.
    rd_r = '1;
    exp_w = pick();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rr_grant", grant_id, exp_w);
      chk("rr_busy", busy, 1);
      @(negedge clk);
      chk("rr_rd_req", bu_rd_req, 1);
      bu_trans_rdy = 1'b1;
      @(negedge clk);
      bu_trans_rdy = 1'b0;
      if (t == 3) clear_reqs();
      chk("rr_done_busy", busy, 0);
      @(negedge clk);
      chk("rr_idle_busy", busy, 0);
      last_win = exp_w;
      exp_w = (exp_w + 1) % NCH;
    end

    // Randomized transactions against the reference model.
    for (int r = 0; r < 40; r++) begin
      rand_inputs();
      run_txn($urandom_range(0, 4), 1'b0, $urandom_range(0, 2));
    end

`ifdef BU_TIMEOUT_EN
    // Bus never responds: the watchdog error arrives TOUT cycles after GRANT.
    rd_r[0] = 1'b1;
    exp_w = pick();
    @(negedge clk);
    chk("to_grant", busy, 1);
    rd_r[0] = 1'b0;
    for (int j = 1; j < TOUT; j++) begin
      @(negedge clk);
      chk("to_quiet", ch_bus_error, 0);
    end
    @(negedge clk);
    chk("to_pulse", ch_bus_error, oh(1'b1, exp_w));
    @(negedge clk);
    chk("to_done_busy", busy, 0);
    chk("to_done_req", {bu_wt_req, bu_rdline_req, bu_rd_req}, 0);
    chk("to_done_err", ch_bus_error, 0);
    @(negedge clk);
    last_win = exp_w;
`endif

    // Reset in the middle of BUSY aborts the transaction at once.
    rd_r[0] = 1'b1; rd_r[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_req", bu_rd_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", {bu_wt_req, bu_rdline_req, bu_rd_req}, 0);
    chk("mid_rst_grant", grant_id, 0);
    rst = 1'b0;
    clear_reqs();
    last_win = NCH - 1;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);

    // After reset, channel 0 wins first again.
    rd_r = '1;
    run_txn(1, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
